// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings for the sequential ALU
// Contents: base ALUop codes, M-extension funct3 codes, FSM state type.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;

   localparam logic [2:0] MD_MUL    = 3'b000;
   localparam logic [2:0] MD_MULH   = 3'b001;
   localparam logic [2:0] MD_MULHSU = 3'b010;
   localparam logic [2:0] MD_MULHU  = 3'b011;
   localparam logic [2:0] MD_DIV    = 3'b100;
   localparam logic [2:0] MD_DIVU   = 3'b101;
   localparam logic [2:0] MD_REM    = 3'b110;
   localparam logic [2:0] MD_REMU   = 3'b111;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

endpackage

// File: rtl/alu_base.sv
// rtl/alu_base.sv - combinational RV32I-style base ALU datapath
// Ports: a, b - operands; alu_op - base op code; result - combinational result.
module alu_base #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [3:0]      alu_op,
   output logic [XLEN-1:0] result
);
   import alu_pkg::*;

   localparam int SHW = $clog2(XLEN);

   // Only the low SHW bits of b form the shift amount.
   logic [SHW-1:0] shamt;
   assign shamt = b[SHW-1:0];

   always_comb begin
      result = '0;
      case (alu_op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_SLL:  result = a << shamt;
         ALU_SRL:  result = a >> shamt;
         ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
         ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with iterative RV32M multiply/divide
// Ports: clk, rst_n (async active-low), flush (sync abort);
//        in_valid/in_ready + A, B, ALUop, md_en, md_op - operation input;
//        out_valid/out_ready + ALUS - registered result; busy - MUL/DIV running.
module alu_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic [3:0]      ALUop,
   input  logic            md_en,
   input  logic [2:0]      md_op,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] ALUS,
   output logic            busy
);
   import alu_pkg::*;

   localparam int SHW = $clog2(XLEN);
   localparam logic [SHW-1:0]  CNT_INIT = SHW'(XLEN-1);
   localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

   state_t state, state_nxt;

   logic [SHW-1:0]    cnt;
   logic              sel_hi, sel_rem, neg_res, neg_rem;
   logic [XLEN-1:0]   mag_b;
   logic [2*XLEN-1:0] acc;

   logic              accept, is_div, a_signed, b_signed, a_neg, b_neg;
   logic              special;
   logic [XLEN-1:0]   special_res, mag_a_c, mag_b_c, base_res;
   logic [XLEN:0]     mul_sum, rem_sh, div_diff;
   logic [2*XLEN-1:0] mul_next, div_next, prod_s;
   logic [XLEN-1:0]   quot, rem, mul_res, div_res;

   alu_base #(.XLEN(XLEN)) u_base (
      .a      (A),
      .b      (B),
      .alu_op (ALUop),
      .result (base_res)
   );

   // flush wins over a coincident handshake.
   assign accept = in_valid && in_ready && !flush;
   assign is_div = md_op[2];

   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (md_op)
         MD_MULH, MD_DIV, MD_REM: begin
            a_signed = 1'b1;
            b_signed = 1'b1;
         end
         MD_MULHSU: a_signed = 1'b1;
         default: ;
      endcase
   end

   assign a_neg   = a_signed && A[XLEN-1];
   assign b_neg   = b_signed && B[XLEN-1];
   assign mag_a_c = a_neg ? -A : A;
   assign mag_b_c = b_neg ? -B : B;

   // Divide-by-zero and signed overflow never enter the iterative loop.
   always_comb begin
      special     = 1'b0;
      special_res = '0;
      if (is_div) begin
         if (B == '0) begin
            special     = 1'b1;
            special_res = md_op[1] ? A : '1;
         end else if (a_signed && A == MIN_VAL && B == '1) begin
            special     = 1'b1;
            special_res = md_op[1] ? '0 : A;
         end
      end
   end

   // Shift-add step: conditionally add the multiplicand into the high half,
   // then shift the whole product right, keeping the carry.
   assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mag_b : {XLEN{1'b0}})};
   assign mul_next = {mul_sum, acc[XLEN-1:1]};
   assign prod_s   = neg_res ? -mul_next : mul_next;
   assign mul_res  = sel_hi ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];

   // Restoring step: shift the remainder left by one, try subtracting the
   // divisor, keep the difference only when it did not go negative.
   assign rem_sh   = acc[2*XLEN-1:XLEN-1];
   assign div_diff = rem_sh - {1'b0, mag_b};
   assign div_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
   assign quot     = div_next[XLEN-1:0];
   assign rem      = div_next[2*XLEN-1:XLEN];
   assign div_res  = sel_rem ? (neg_rem ? -rem : rem) : (neg_res ? -quot : quot);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) begin
            if (!md_en || special) state_nxt = DONE;
            else if (is_div)       state_nxt = DIV;
            else                   state_nxt = MUL;
         end
         MUL, DIV: if (cnt == '0) state_nxt = DONE;
         DONE:     if (out_ready) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE:     in_ready  = 1'b1;
         MUL, DIV: busy      = 1'b1;
         DONE:     out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         sel_hi  <= 1'b0;
         sel_rem <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         mag_b   <= '0;
         acc     <= '0;
         ALUS    <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               cnt     <= CNT_INIT;
               sel_hi  <= (md_op != MD_MUL);
               sel_rem <= md_op[1];
               neg_res <= a_neg ^ b_neg;
               neg_rem <= a_neg;
               mag_b   <= mag_b_c;
               acc     <= {{XLEN{1'b0}}, mag_a_c};
               if (!md_en)       ALUS <= base_res;
               else if (special) ALUS <= special_res;
            end
            MUL: begin
               acc <= mul_next;
               if (cnt == '0) ALUS <= mul_res;
               else           cnt  <= cnt - 1'b1;
            end
            DIV: begin
               acc <= div_next;
               if (cnt == '0) ALUS <= div_res;
               else           cnt  <= cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with a reference model
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready, md_en;
   logic [3:0]  ALUop;
   logic [2:0]  md_op;
   logic [31:0] A, B;
   logic        in_ready, out_valid, busy;
   logic [31:0] ALUS;

   int n_vec = 0;
   int n_err = 0;

   logic [3:0] base_ops [10] = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100,
                                 4'b0001, 4'b0101, 4'b1101, 4'b0010, 4'b0011};

   alu_seq #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .ALUop     (ALUop),
      .md_en     (md_en),
      .md_op     (md_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUS      (ALUS),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic straight from the instruction semantics.
   function automatic logic [31:0] model(input logic md, input logic [3:0] aop,
                                          input logic [2:0] mop,
                                          input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, ps;
      logic [63:0]        ua, ub, pu;
      int                 sh;
      logic [31:0]        r;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      sh = int'(b[4:0]);
      r  = 32'd0;
      if (!md) begin
         case (aop)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0111: r = a & b;
            4'b0110: r = a | b;
            4'b0100: r = a ^ b;
            4'b0001: r = a << sh;
            4'b0101: r = a >> sh;
            4'b1101: begin ps = sa >>> sh; r = ps[31:0]; end
            4'b0010: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b0011: r = (ua < ub) ? 32'd1 : 32'd0;
            default: r = 32'd0;
         endcase
      end else begin
         case (mop)
            3'd0: begin pu = ua * ub; r = pu[31:0]; end
            3'd1: begin ps = sa * sb; r = ps[63:32]; end
            3'd2: begin ps = sa * $signed(ub); r = ps[63:32]; end
            3'd3: begin pu = ua * ub; r = pu[63:32]; end
            3'd4: begin
               if (b == 32'd0) r = 32'hFFFFFFFF;
               else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
               else begin ps = sa / sb; r = ps[31:0]; end
            end
            3'd5: begin
               if (b == 32'd0) r = 32'hFFFFFFFF;
               else begin pu = ua / ub; r = pu[31:0]; end
            end
            3'd6: begin
               if (b == 32'd0) r = a;
               else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
               else begin ps = sa % sb; r = ps[31:0]; end
            end
            default: begin
               if (b == 32'd0) r = a;
               else begin pu = ua % ub; r = pu[31:0]; end
            end
         endcase
      end
      return r;
   endfunction

   function automatic int model_lat(input logic md, input logic [2:0] mop,
                                    input logic [31:0] a, input logic [31:0] b);
      if (!md) return 1;
      if (mop[2] && (b == 32'd0 || (!mop[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
         return 1;
      return 33;
   endfunction

   task automatic run_op(input string tag, input logic md, input logic [3:0] aop,
                         input logic [2:0] mop, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat);
      int lat, bcnt, w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 100) begin @(negedge clk); w++; end
      in_valid = 1'b1; md_en = md; ALUop = aop; md_op = mop; A = a; B = b;
      @(posedge clk);
      lat = 0; bcnt = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) in_valid = 1'b0;
         if (busy) bcnt++;
      end while (!out_valid && lat < 200);
      check({tag, " result"}, 64'(ALUS), 64'(exp));
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " busy cycles"}, 64'(bcnt), 64'(exp_lat - 1));
   endtask

   initial begin
      int lat, seen;
      logic        md;
      logic [3:0]  aop;
      logic [2:0]  mop;
      logic [31:0] a, b;
      int          sel;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; md_en = 1'b0;
      ALUop = 4'd0; md_op = 3'd0; A = 32'd0; B = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset in_ready", 64'(in_ready), 64'd1);
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      check("reset ALUS", 64'(ALUS), 64'd0);
      rst_n = 1'b1;

      run_op("ADD",    1'b0, 4'b0000, 3'd0, 32'd5, 32'd7, 32'h0000000C, 1);
      run_op("SUB",    1'b0, 4'b1000, 3'd0, 32'd5, 32'd7, 32'hFFFFFFFE, 1);
      run_op("SLT",    1'b0, 4'b0010, 3'd0, 32'hFFFFFFFB, 32'd5, 32'd1, 1);
      run_op("SLTU",   1'b0, 4'b0011, 3'd0, 32'hFFFFFFFB, 32'd5, 32'd0, 1);
      run_op("SLL",    1'b0, 4'b0001, 3'd0, 32'd5, 32'h00000021, 32'h0000000A, 1);
      run_op("SRA",    1'b0, 4'b1101, 3'd0, 32'h80000000, 32'd4, 32'hF8000000, 1);
      run_op("MULH",   1'b1, 4'b0000, 3'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);
      run_op("MULHU",  1'b1, 4'b0000, 3'd3, 32'hFFFFFFFF, 32'd2, 32'h00000001, 33);
      run_op("MUL",    1'b1, 4'b0000, 3'd0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 33);
      run_op("DIV",    1'b1, 4'b0000, 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
      run_op("REM",    1'b1, 4'b0000, 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
      run_op("DIVU0",  1'b1, 4'b0000, 3'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 1);
      run_op("REMOVF", 1'b1, 4'b0000, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

      // Backpressure on a completed DIVU.
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; md_en = 1'b1; md_op = 3'd5; A = 32'd1000; B = 32'd7;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) in_valid = 1'b0;
      end while (!out_valid && lat < 200);
      check("stall latency", 64'(lat), 64'd33);
      repeat (10) begin
         @(negedge clk);
         check("stall ALUS", 64'(ALUS), 64'd142);
         check("stall out_valid", 64'(out_valid), 64'd1);
         check("stall in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      check("release same-cycle in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("release in_ready", 64'(in_ready), 64'd1);
      check("release out_valid", 64'(out_valid), 64'd0);

      // flush at iteration 10 of a MUL.
      in_valid = 1'b1; md_en = 1'b1; md_op = 3'd0; A = $urandom; B = $urandom;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("pre-flush busy", 64'(busy), 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush busy", 64'(busy), 64'd0);
      check("flush in_ready", 64'(in_ready), 64'd1);
      check("flush out_valid", 64'(out_valid), 64'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen = 1;
      end
      check("flush no result", 64'(seen), 64'd0);

      // flush coincident with an accept discards it.
      in_valid = 1'b1; flush = 1'b1; md_en = 1'b0; ALUop = 4'b0000; A = 32'd1; B = 32'd2;
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0;
      check("flush+accept in_ready", 64'(in_ready), 64'd1);
      check("flush+accept out_valid", 64'(out_valid), 64'd0);

      // Asynchronous reset in the middle of a DIV.
      in_valid = 1'b1; md_en = 1'b1; md_op = 3'd4; A = 32'd1000; B = 32'd7;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async reset busy", 64'(busy), 64'd0);
      check("async reset in_ready", 64'(in_ready), 64'd1);
      check("async reset out_valid", 64'(out_valid), 64'd0);
      check("async reset ALUS", 64'(ALUS), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomised operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         md  = 1'($urandom_range(0, 1));
         aop = base_ops[$urandom_range(0, 9)];
         mop = 3'($urandom_range(0, 7));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0) b = 32'd0;
         else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
         else if (sel == 2) b = 32'($urandom_range(1, 40));
         run_op("random", md, aop, mop, a, b, model(md, aop, mop, a, b),
                model_lat(md, mop, a, b));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle RV32I ALU.
- Executes all base ALU operations with a registered result.
- Adds the RV32M multiply/divide operations, executed iteratively: one bit per cycle, shift-add for multiply, restoring division for divide.
- Sits between decode and writeback in the upcoming multi-cycle datapath. Valid/ready on both sides lets the control FSM stall on long operations.

Parameters:
- XLEN, 32, operand/result width; power of two, 8 to 64.
- SHW, $clog2(XLEN), shift-amount width (derived, not overridable).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; clears any operation in flight.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- A  in  XLEN  operand A (rs1).
- B  in  XLEN  operand B (rs2 or immediate).
- ALUop  in  4  base op, same encoding as the current ALU: 0000 ADD, 1000 SUB, 0111 AND, 0110 OR, 0100 XOR, 0001 SLL, 0101 SRL, 1101 SRA, 0010 SLT, 0011 SLTU.
- md_en  in  1  1 selects an M-extension op; ALUop is then ignored.
- md_op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- out_valid  out  1  ALUS holds a result.
- out_ready  in  1  consumer takes the result.
- ALUS  out  XLEN  result.
- busy  out  1  iterative operation in progress.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, ALUS=0, busy=0; all internal registers cleared.
- Accept: in_valid && in_ready at a rising edge. Operands, op, sign flags and the md_en decode are captured that edge.
- States:
  - IDLE: on accept with md_en=0 -> DONE. ALUS is computed that edge, so out_valid rises the next cycle (latency 1).
  - IDLE: on accept with md_en=1 -> MUL or DIV. Exception: special-case divides go straight to DONE with latency 1.
  - MUL: runs XLEN iterations on the operand magnitudes; counter from XLEN-1 down to 0. At count 0: apply result sign and select the low or high word -> DONE. Latency XLEN+1 from acceptance.
  - DIV: runs XLEN iterations of restoring division on the magnitudes; the 2*XLEN remainder/quotient register shifts left 1 per cycle. At count 0: apply signs -> DONE. Latency XLEN+1.
  - DONE: out_valid=1 and ALUS is held stable until out_ready. Then -> IDLE; in_ready rises the following cycle (no same-cycle re-accept).
- Stall: in DONE with out_ready=0, ALUS and out_valid are held indefinitely.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Signed ops negate the magnitude results when the signs differ.
  - The remainder sign follows the dividend.
  - The full 2*XLEN product is formed internally. MUL returns the low half; MULH* return the high half.
- Division special cases (resolved in IDLE, latency 1):
  - B=0: DIV/DIVU return all-ones; REM/REMU return A.
  - Signed overflow, A=100..0 and B=all-ones: DIV returns A; REM returns 0.
- Shifts use B[SHW-1:0] only; upper bits of B are ignored. SRA replicates A[XLEN-1].
- SLT/SLTU return a zero-extended 1 or 0.
- ADD/SUB wrap modulo 2^XLEN; there is no flag output.
- flush: highest priority after reset. From any state -> IDLE next edge: out_valid=0, busy=0, counter cleared; ALUS is not required to clear. flush coincident with accept discards the accept.
- Reset mid-operation: immediate return to reset values; no partial result appears.
- busy=1 exactly in MUL and DIV.
- in_valid while in_ready=0 is ignored. The producer holds its inputs until accepted.

Decomposition:
- Package alu_pkg:
  - ALUop localparams (ALU_ADD, ALU_SUB, ...).
  - md_op localparams (MD_MUL ... MD_REMU).
  - State typedef enum logic [1:0] {IDLE, MUL, DIV, DONE}.
- Sub-module alu_base: combinational, XLEN-parametrised base-op datapath (the current ALU behaviour generalised). alu_seq instantiates it and registers its output.
- The multiply/divide datapath and the FSM stay in alu_seq.

Test Plan (XLEN=32):
- Base op: ALUop=0000, A=5, B=7 -> out_valid 1 cycle after accept, ALUS=0x0000000C. Repeat for SUB 5-7 -> 0xFFFFFFFE. Repeat SLT with A=-5, B=5 -> 1; SLTU, same operands -> 0.
- Shift masking: SLL, A=5, B=0x00000021 -> ALUS=0x0000000A. SRA, A=0x80000000, B=4 -> 0xF8000000.
- Multiply: MULH, A=0xFFFFFFFF (-1), B=2 -> 0xFFFFFFFF after 33 cycles with busy high 32 cycles. MULHU, same operands -> 0x00000001. MUL, same operands -> 0xFFFFFFFE.
- Divide: DIV, A=-7, B=2 -> -3 (0xFFFFFFFD). REM, same operands -> -1. DIVU, A=0x80000000, B=0 -> 0xFFFFFFFF after 1 cycle. REM, A=0x80000000, B=-1 -> 0.
- Backpressure: complete a DIVU with out_ready=0 for 10 cycles -> ALUS stable, in_ready=0; when out_ready rises, in_ready goes high the next cycle.
- flush at iteration 10 of a MUL -> IDLE next edge, busy=0, out_valid never rises. rst_n pulsed low mid-DIV -> all outputs at reset values asynchronously.
